// File: rtl/grc_sample_framer.sv
// Splits reader words into I/Q samples and frames them with last_o; 1-cycle latency from accept to valid_o.
// Output register plus one skid entry (2 entries total) with registered ready_o; no word is dropped or duplicated under backpressure.
module grc_sample_framer #(
   parameter int NUM_BYTES  = 4,
   parameter int FRAME_SIZE = 256,
   parameter int SWAP_IQ    = 0
) (
   input  logic                     clk,
   input  logic                     sync_reset,
   input  logic                     valid_i,
   input  logic [NUM_BYTES*8-1:0]   word_i,
   input  logic                     buffer_end_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [NUM_BYTES*4-1:0]   i_o,
   output logic [NUM_BYTES*4-1:0]   q_o,
   output logic                     last_o,
   input  logic                     ready_i,
   output logic [31:0]              frame_cnt_o,
   output logic                     short_frame_o,
   output logic                     done_o
);
   localparam int WORD_BITS = NUM_BYTES * 8;
   localparam int HALF      = WORD_BITS / 2;
   localparam int CW        = (FRAME_SIZE > 2) ? $clog2(FRAME_SIZE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_SIZE - 1);

   typedef struct packed {
      logic [HALF-1:0] i;
      logic [HALF-1:0] q;
      logic            last;
      logic            fin;
   } entry_t;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t          state_q;
   entry_t          out_q, sk_q, in_ent;
   logic            out_vld_q, sk_vld_q, ready_q, short_q, done_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     frame_cnt_q;
   logic            acc, xfer, in_last, run_d, ready_d;
   logic [1:0]      occ, occ_d;

   assign acc     = valid_i & ready_q;
   assign xfer    = out_vld_q & ready_i;
   assign in_last = (cnt_q == CNT_MAX) | buffer_end_i;

   always_comb begin
      in_ent      = '0;
      in_ent.i    = (SWAP_IQ != 0) ? word_i[HALF-1:0] : word_i[WORD_BITS-1:HALF];
      in_ent.q    = (SWAP_IQ != 0) ? word_i[WORD_BITS-1:HALF] : word_i[HALF-1:0];
      in_ent.last = in_last;
      in_ent.fin  = buffer_end_i;
   end

   // Occupancy counts the output register as one of the two entries.
   assign occ     = {1'b0, out_vld_q} + {1'b0, sk_vld_q};
   assign occ_d   = occ + {1'b0, acc} - {1'b0, xfer};
   assign run_d   = (state_q == RUN) && !(acc && buffer_end_i);
   assign ready_d = run_d && (occ_d < 2'd2);

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q     <= RUN;
         out_q       <= '0;
         sk_q        <= '0;
         out_vld_q   <= 1'b0;
         sk_vld_q    <= 1'b0;
         ready_q     <= 1'b0;
         short_q     <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         ready_q <= ready_d;

         if (acc)
            cnt_q <= in_last ? '0 : cnt_q + CW'(1);

         if (!out_vld_q || xfer) begin
            if (sk_vld_q) begin
               out_q     <= sk_q;
               out_vld_q <= 1'b1;
               sk_vld_q  <= acc;
               if (acc)
                  sk_q <= in_ent;
            end else begin
               out_vld_q <= acc;
               if (acc)
                  out_q <= in_ent;
            end
         end else if (acc) begin
            sk_q     <= in_ent;
            sk_vld_q <= 1'b1;
         end

         if (xfer && out_q.last)
            frame_cnt_q <= frame_cnt_q + 32'd1;

         case (state_q)
            RUN: begin
               if (acc && buffer_end_i) begin
                  state_q <= DRAIN;
                  short_q <= (cnt_q != CNT_MAX);
               end
            end
            DRAIN: begin
               if (xfer && out_q.fin) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= DONE;
         endcase
      end
   end

   assign ready_o       = ready_q;
   assign valid_o       = out_vld_q;
   assign i_o           = out_q.i;
   assign q_o           = out_q.q;
   assign last_o        = out_q.last;
   assign frame_cnt_o   = frame_cnt_q;
   assign short_frame_o = short_q;
   assign done_o        = done_q;
endmodule

// File: tb/tb_grc_sample_framer.sv
// Bench for grc_sample_framer: table-driven word stream, scoreboard on output transfers, two DUTs (SWAP_IQ 0 and 1).
module tb_grc_sample_framer;
   logic        clk = 1'b0;
   logic        sync_reset, valid_i, buffer_end_i, ready_i;
   logic [31:0] word_i;
   logic        ready_o, valid_o, last_o, short_frame_o, done_o;
   logic [15:0] i_o, q_o;
   logic [31:0] frame_cnt_o;
   logic        s_ready_o, s_valid_o, s_last_o, s_short_frame_o, s_done_o;
   logic [15:0] s_i_o, s_q_o;
   logic [31:0] s_frame_cnt_o;

   always #5 clk = ~clk;

   grc_sample_framer #(.NUM_BYTES(4), .FRAME_SIZE(4), .SWAP_IQ(0)) u0 (
      .clk(clk), .sync_reset(sync_reset), .valid_i(valid_i), .word_i(word_i),
      .buffer_end_i(buffer_end_i), .ready_o(ready_o), .valid_o(valid_o),
      .i_o(i_o), .q_o(q_o), .last_o(last_o), .ready_i(ready_i),
      .frame_cnt_o(frame_cnt_o), .short_frame_o(short_frame_o), .done_o(done_o));

   grc_sample_framer #(.NUM_BYTES(4), .FRAME_SIZE(4), .SWAP_IQ(1)) u1 (
      .clk(clk), .sync_reset(sync_reset), .valid_i(valid_i), .word_i(word_i),
      .buffer_end_i(buffer_end_i), .ready_o(s_ready_o), .valid_o(s_valid_o),
      .i_o(s_i_o), .q_o(s_q_o), .last_o(s_last_o), .ready_i(ready_i),
      .frame_cnt_o(s_frame_cnt_o), .short_frame_o(s_short_frame_o), .done_o(s_done_o));

   typedef struct {
      logic [31:0] word;
      logic [15:0] ei;
      logic [15:0] eq;
      logic        el;
   } vec_t;

   typedef struct {
      logic [15:0] i;
      logic [15:0] q;
      logic        last;
      logic        fin;
   } exp_t;

   vec_t  tbl [8];
   exp_t  sb [$];
   exp_t  cur_exp, mon_e;
   int    checks = 0, passed = 0;
   int    rmode = 0, rcyc = 0, acc_cnt = 0;
   logic  rdy_chk_en = 1'b0, end_seen = 1'b0, hold_pend = 1'b0, done_chk = 1'b0;
   logic [31:0] hold_iq;
   logic        hold_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
   endtask

   // Downstream ready pattern: 0 = always ready, 1 = 1,0,0,1 toggle, 2 = stalled.
   initial forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (rmode)
         0: ready_i = 1'b1;
         1: ready_i = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
         default: ready_i = 1'b0;
      endcase
   end

   // Monitor: checks ready_o against the model occupancy, scoreboards transfers.
   initial forever begin
      @(negedge clk);
      if (sync_reset) begin
         sb.delete();
         hold_pend = 1'b0;
         done_chk  = 1'b0;
      end else begin
         if (done_chk) begin
            chk("done_after_final", done_o, 1);
            chk("valid_after_done", valid_o, 0);
            done_chk = 1'b0;
         end
         if (rdy_chk_en)
            chk("ready_o", ready_o, (sb.size() < 2) && !end_seen);
         if (hold_pend) begin
            chk("hold_iq", {i_o, q_o}, hold_iq);
            chk("hold_last", last_o, hold_last);
         end
         hold_pend = valid_o && !ready_i;
         hold_iq   = {i_o, q_o};
         hold_last = last_o;
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("i_o", i_o, mon_e.i);
               chk("q_o", q_o, mon_e.q);
               chk("last_o", last_o, mon_e.last);
               chk("swap_i_o", {s_valid_o, s_i_o}, {1'b1, mon_e.q});
               chk("swap_q_o", s_q_o, mon_e.i);
               if (mon_e.fin) begin
                  chk("done_early", done_o, 0);
                  done_chk = 1'b1;
               end
            end
         end
         if (valid_i && ready_o) begin
            sb.push_back(cur_exp);
            acc_cnt++;
            if (cur_exp.fin) end_seen = 1'b1;
         end
      end
   end

   task automatic do_reset();
      rdy_chk_en = 1'b0;
      sync_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_iq", {i_o, q_o}, 0);
      chk("rst_last", last_o, 0);
      chk("rst_frame_cnt", frame_cnt_o, 0);
      chk("rst_short", short_frame_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", ready_o, 0);
      sync_reset   = 1'b0;
      valid_i      = 1'b0;
      buffer_end_i = 1'b0;
      sb.delete();
      end_seen = 1'b0;
      acc_cnt  = 0;
      @(posedge clk);
      #1;
      rdy_chk_en = 1'b1;
   endtask

   task automatic drive_word(input logic [31:0] w, input logic e);
      logic got;
      got          = 1'b0;
      word_i       = w;
      buffer_end_i = e;
      valid_i      = 1'b1;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = ready_o;
         @(posedge clk);
         #1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      valid_i      = 1'b0;
      buffer_end_i = 1'b0;
   endtask

   task automatic stream(input int n);
      logic fin_ok;
      for (int k = 0; k < n; k++) begin
         cur_exp.i    = tbl[k].ei;
         cur_exp.q    = tbl[k].eq;
         cur_exp.last = tbl[k].el || (k == n - 1);
         cur_exp.fin  = (k == n - 1);
         drive_word(tbl[k].word, k == n - 1);
      end
      fin_ok = 1'b0;
      for (int c = 0; c < 100 && !fin_ok; c++) begin
         @(negedge clk);
         fin_ok = done_o && (sb.size() == 0);
      end
      if (!fin_ok) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h0001_0002, 16'd1, 16'd2, 1'b0};
      tbl[1] = '{32'h0002_0003, 16'd2, 16'd3, 1'b0};
      tbl[2] = '{32'h0003_0004, 16'd3, 16'd4, 1'b0};
      tbl[3] = '{32'h0004_0005, 16'd4, 16'd5, 1'b1};
      tbl[4] = '{32'h0005_0006, 16'd5, 16'd6, 1'b0};
      tbl[5] = '{32'h0006_0007, 16'd6, 16'd7, 1'b0};
      tbl[6] = '{32'h0007_0008, 16'd7, 16'd8, 1'b0};
      tbl[7] = '{32'h0008_0009, 16'd8, 16'd9, 1'b1};

      sync_reset   = 1'b1;
      valid_i      = 1'b0;
      word_i       = '0;
      buffer_end_i = 1'b0;
      ready_i      = 1'b1;
      cur_exp      = '{16'd0, 16'd0, 1'b0, 1'b0};

      // Full 8-word file, always ready.
      do_reset();
      rmode = 0;
      stream(8);
      chk("frames_8_words", frame_cnt_o, 2);
      chk("short_8_words", short_frame_o, 0);
      chk("done_8_words", done_o, 1);

      // Same file under 1,0,0,1 backpressure.
      do_reset();
      rmode = 1;
      stream(8);
      chk("frames_toggle", frame_cnt_o, 2);
      chk("short_toggle", short_frame_o, 0);

      // Short final frame.
      do_reset();
      rmode = 0;
      stream(6);
      chk("frames_6_words", frame_cnt_o, 2);
      chk("short_6_words", short_frame_o, 1);

      // Long stall: only output register + skid entry may fill.
      do_reset();
      rmode = 2;
      cur_exp = '{tbl[0].ei, tbl[0].eq, 1'b0, 1'b0};
      drive_word(tbl[0].word, 1'b0);
      cur_exp = '{tbl[1].ei, tbl[1].eq, 1'b0, 1'b0};
      drive_word(tbl[1].word, 1'b0);
      cur_exp      = '{tbl[2].ei, tbl[2].eq, 1'b0, 1'b0};
      word_i       = tbl[2].word;
      valid_i      = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("stall_accepted", acc_cnt, 2);
      chk("stall_valid", valid_o, 1);
      chk("stall_i_o", i_o, 16'd1);

      // Reset with skid full and downstream stalled, then a clean 4-word file.
      do_reset();
      rmode = 0;
      stream(4);
      chk("frames_after_rst", frame_cnt_o, 1);
      chk("short_after_rst", short_frame_o, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/grc_sample_framer.md
Name: grc_sample_framer

Overview:
- Downstream stage of the testbench file reader.
- Consumes its valid/ready word stream plus the end-of-buffer flag.
- Splits each word into I and Q halves and emits a framed complex-sample stream, with `last_o` on every FRAME_SIZE-th sample and on the final sample of the file.
- Contains a 2-entry skid buffer so backpressure from the DUT never loses or duplicates a word.

Parameters:
- NUM_BYTES, 4, bytes per input word; must be even. WORD_BITS = NUM_BYTES*8; HALF = WORD_BITS/2.
- FRAME_SIZE, 256, samples per output frame; must be ≥ 2.
- SWAP_IQ, 0, 0: I = word[WORD_BITS-1:HALF], Q = word[HALF-1:0]; 1: halves swapped.

Ports:
- clk  input  1  system clock, all logic on rising edge
- sync_reset  input  1  synchronous, active-high reset
- valid_i  input  1  input word valid (from reader valid_o)
- word_i  input  WORD_BITS  input word (from reader word_o)
- buffer_end_i  input  1  high on the beat carrying the final word of the file
- ready_o  output  1  framer can accept a word (to reader ready_i)
- valid_o  output  1  output sample valid
- i_o  output  HALF  in-phase sample
- q_o  output  HALF  quadrature sample
- last_o  output  1  final sample of current frame
- ready_i  input  1  downstream ready
- frame_cnt_o  output  32  frames completed (incremented on each accepted last beat)
- short_frame_o  output  1  sticky; final frame had fewer than FRAME_SIZE samples
- done_o  output  1  final sample has left the output register

Behaviour:
- Reset values (sync_reset high at a rising edge; wins over all other activity, including mid-frame and with skid buffer full):
  - valid_o=0, i_o=0, q_o=0, last_o=0, frame_cnt_o=0, short_frame_o=0, done_o=0, ready_o=0.
  - Sample counter=0, skid buffer empty, state=RUN.
  - ready_o goes high the first cycle after reset deasserts.
- Input accept: valid_i & ready_o at a rising edge.
- Output transfer: valid_o & ready_i at a rising edge.
- Output register: i_o/q_o/last_o hold stable while valid_o & !ready_i.
- Latency: a word accepted into an empty path appears on valid_o the next cycle.
- Skid buffer, 2 entries, each holding {word, last flag}:
  - ready_o is registered, and is high iff fewer than 2 entries will be occupied after this cycle's accept/transfer.
  - Simultaneous accept and transfer with 1 entry occupied leaves occupancy at 1.
  - A full buffer with ready_i held low keeps ready_o low. No drop, no overwrite.
  - Order is strict FIFO.
- Framing:
  - The sample counter (width clog2(FRAME_SIZE)) increments per accepted input word.
  - last flag = (count == FRAME_SIZE-1) | buffer_end_i.
  - The counter clears to 0 when the last flag is set.
  - The last flag is computed at accept time and travels with the word.
- frame_cnt_o:
  - Increments on each output transfer with last_o=1.
  - Wraps from 2^32-1 to 0.
- State machine:
  - RUN → DRAIN on an accepted word with buffer_end_i=1.
    - In that cycle: short_frame_o <= (count != FRAME_SIZE-1).
    - Note: when buffer_end coincides with a natural frame boundary, short_frame_o = 0.
  - DRAIN: ready_o forced 0; remaining entries are emitted normally. DRAIN → DONE on the output transfer of the entry carrying buffer_end.
  - DONE: done_o=1, ready_o=0, valid_o=0. Held until sync_reset.
- buffer_end_i without valid_i is ignored.
- valid_i while ready_o=0 is not accepted. The upstream reader holds its word.

Test Plan:
- FRAME_SIZE=4, NUM_BYTES=4, SWAP_IQ=0; 8 words 0x00010002..0x00080009, ready_i=1, buffer_end_i on word 8:
  - i_o=1..8, q_o=2..9.
  - last_o on samples 4 and 8.
  - frame_cnt_o=2, short_frame_o=0, done_o=1 one cycle after sample 8 transfers.
- Same stream with SWAP_IQ=1 -> i_o=2..9, q_o=1..8.
- Same 8 words with ready_i toggling 1,0,0,1 repeatedly -> ready_o low only while 2 entries are held; output sequence identical to the first scenario with no duplicates.
- FRAME_SIZE=4, 6 words, buffer_end_i on word 6 -> last_o on samples 4 and 6; frame_cnt_o=2; short_frame_o=1; ready_o=0 from the cycle after word 6 is accepted.
- Reset mid-frame: assert sync_reset after 2 of 4 samples with the skid buffer full and ready_i=0 -> next cycle all outputs zero; after release, a new 4-word stream gives last_o on its 4th sample and frame_cnt_o=1.
- ready_i=0 for 20 cycles after 1 sample is valid -> i_o/q_o/last_o stable throughout; exactly 2 words accepted in total (1 in the output register, 1 in the skid entry).
